// File: rtl/reg_access_master_if.sv
// Host-facing request/response channel of reg_access_master.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge, and ready never waits on valid.
interface reg_access_master_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    // master: the reg_access_master side; slave: the host issuing requests
    modport master (
        input  req_valid, req_write, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_write, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/reg_access_master.sv
// Initiator for a single 16-bit storage register: turns host read/write requests into
// one-cycle enable pulses and returns the captured data_out, with optional write readback.
module reg_access_master #(
    parameter int WIDTH  = 16,
    parameter bit VERIFY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_access_master_if.master  host,
    output logic [7:0]           err_count,
    output logic                 reg_write_enable,
    output logic                 reg_read_enable,
    output logic [WIDTH-1:0]     reg_data_in,
    input  logic [WIDTH-1:0]     reg_data_out,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             op;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             mismatch;

    assign mismatch = (reg_data_out != wdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op         <= 1'b0;
            wdata      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (host.req_valid) begin
                        op    <= host.req_write;
                        wdata <= host.req_data;
                    end
                end
                WR: begin
                    if (!VERIFY) begin
                        rsp_data_q <= wdata;
                        rsp_err_q  <= 1'b0;
                    end
                end
                // data_out was loaded by the RD pulse one edge earlier
                CAP: begin
                    rsp_data_q <= reg_data_out;
                    if (op && mismatch) begin
                        rsp_err_q <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        rsp_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next       = state;
        host.req_ready   = 1'b0;
        host.rsp_valid   = 1'b0;
        reg_write_enable = 1'b0;
        reg_read_enable  = 1'b0;
        case (state)
            IDLE: begin
                host.req_ready = 1'b1;
                if (host.req_valid) begin
                    state_next = host.req_write ? WR : RD;
                end
            end
            WR: begin
                reg_write_enable = 1'b1;
                state_next       = VERIFY ? RD : RSP;
            end
            RD: begin
                reg_read_enable = 1'b1;
                state_next      = CAP;
            end
            CAP: state_next = RSP;
            RSP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign host.rsp_data = rsp_data_q;
    assign host.rsp_err  = rsp_err_q;
    assign reg_data_in   = wdata;
    assign dbg_state     = state;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: a VERIFY=1 and a VERIFY=0 instance, each with its own register model.
module tb_reg_access_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_access_master_if #(.WIDTH(16)) if1 ();
    reg_access_master_if #(.WIDTH(16)) if0 ();

    logic [7:0]  err_count1, err_count0;
    logic        we1, re1, we0, re0;
    logic [15:0] din1, din0, dout1, dout0;
    logic [2:0]  dbg1, dbg0;
    logic [15:0] st1, st0;
    logic        fault_mode = 1'b0;

    int total  = 0;
    int passed = 0;
    int acc1   = 0;

    reg_access_master #(.WIDTH(16), .VERIFY(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .host(if1.master), .err_count(err_count1),
        .reg_write_enable(we1), .reg_read_enable(re1), .reg_data_in(din1),
        .reg_data_out(dout1), .dbg_state(dbg1)
    );

    reg_access_master #(.WIDTH(16), .VERIFY(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .host(if0.master), .err_count(err_count0),
        .reg_write_enable(we0), .reg_read_enable(re0), .reg_data_in(din0),
        .reg_data_out(dout0), .dbg_state(dbg0)
    );

    // Storage register models: write clears data_out, read loads it; fault_mode forces readback to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st1 <= 16'h0; dout1 <= 16'h0;
        end else if (we1) begin
            st1 <= din1; dout1 <= 16'h0;
        end else if (re1) begin
            dout1 <= fault_mode ? 16'h0 : st1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st0 <= 16'h0; dout0 <= 16'h0;
        end else if (we0) begin
            st0 <= din0; dout0 <= 16'h0;
        end else if (re0) begin
            dout0 <= st0;
        end
    end

    always @(posedge clk) begin
        if (if1.req_valid && if1.req_ready) acc1 <= acc1 + 1;
    end

    // Driver: one full transaction on the selected instance, recording pulse timing and latency
    task automatic run_txn(input bit sel, input logic wr, input logic [15:0] d,
                           output int lat, output int wr_n, output int rd_n,
                           output int wr_at, output int rd_at,
                           output logic [15:0] q, output logic e);
        lat = -1; wr_n = 0; rd_n = 0; wr_at = 0; rd_at = 0; q = 16'hxxxx; e = 1'bx;
        @(negedge clk);
        if (sel) begin if1.req_valid = 1'b1; if1.req_write = wr; if1.req_data = d; end
        else     begin if0.req_valid = 1'b1; if0.req_write = wr; if0.req_data = d; end
        @(posedge clk); #1;
        if1.req_valid = 1'b0; if0.req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (sel ? we1 : we0) begin wr_n++; wr_at = n; end
            if (sel ? re1 : re0) begin rd_n++; rd_at = n; end
            if (sel ? if1.rsp_valid : if0.rsp_valid) begin lat = n; break; end
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            q = sel ? if1.rsp_data : if0.rsp_data;
            e = sel ? if1.rsp_err : if0.rsp_err;
            if (sel) if1.rsp_ready = 1'b1; else if0.rsp_ready = 1'b1;
            @(posedge clk); #1;
            if1.rsp_ready = 1'b0; if0.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (if1.req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", if1.req_ready); else passed++;
        total++; if (if1.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", if1.rsp_valid); else passed++;
        total++; if (if1.rsp_data !== 16'h0) $display("FAIL rst_rsp_data got %h want 0000", if1.rsp_data); else passed++;
        total++; if (if1.rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", if1.rsp_err); else passed++;
        total++; if (err_count1 !== 8'd0) $display("FAIL rst_err_count got %0d want 0", err_count1); else passed++;
        total++; if ({we1, re1} !== 2'b00) $display("FAIL rst_enables got %b want 00", {we1, re1}); else passed++;
        total++; if (din1 !== 16'h0) $display("FAIL rst_data_in got %h want 0000", din1); else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (dbg1 !== 3'd0) $display("FAIL rst_idle_state got %0d want 0", dbg1); else passed++;
    endtask

    task automatic test_read_after_reset();
        int lat, wn, rn, wa, ra; logic [15:0] q; logic e;
        run_txn(1'b1, 1'b0, 16'hFFFF, lat, wn, rn, wa, ra, q, e);
        total++; if (lat !== 3) $display("FAIL rd0_latency got %0d want 3", lat); else passed++;
        total++; if (rn !== 1 || ra !== 1) $display("FAIL rd0_read_pulse got n=%0d at=%0d want n=1 at=1", rn, ra); else passed++;
        total++; if (wn !== 0) $display("FAIL rd0_write_pulse got %0d want 0", wn); else passed++;
        total++; if (q !== 16'h0000) $display("FAIL rd0_data got %h want 0000", q); else passed++;
        total++; if (e !== 1'b0) $display("FAIL rd0_err got %b want 0", e); else passed++;
    endtask

    task automatic test_write_verify();
        int lat, wn, rn, wa, ra; logic [15:0] q; logic e;
        run_txn(1'b1, 1'b1, 16'hA5A5, lat, wn, rn, wa, ra, q, e);
        total++; if (lat !== 4) $display("FAIL wv_latency got %0d want 4", lat); else passed++;
        total++; if (wn !== 1 || wa !== 1) $display("FAIL wv_write_pulse got n=%0d at=%0d want n=1 at=1", wn, wa); else passed++;
        total++; if (rn !== 1 || ra !== 2) $display("FAIL wv_read_pulse got n=%0d at=%0d want n=1 at=2", rn, ra); else passed++;
        total++; if (q !== 16'hA5A5) $display("FAIL wv_data got %h want a5a5", q); else passed++;
        total++; if (e !== 1'b0) $display("FAIL wv_err got %b want 0", e); else passed++;
        total++; if (err_count1 !== 8'd0) $display("FAIL wv_err_count got %0d want 0", err_count1); else passed++;
        run_txn(1'b1, 1'b0, 16'h0000, lat, wn, rn, wa, ra, q, e);
        total++; if (q !== 16'hA5A5) $display("FAIL wv_readback got %h want a5a5", q); else passed++;
        total++; if (lat !== 3) $display("FAIL wv_read_latency got %0d want 3", lat); else passed++;
    endtask

    task automatic test_no_verify();
        int lat, wn, rn, wa, ra; logic [15:0] q; logic e;
        run_txn(1'b0, 1'b1, 16'h1234, lat, wn, rn, wa, ra, q, e);
        total++; if (lat !== 2) $display("FAIL nv_latency got %0d want 2", lat); else passed++;
        total++; if (wn !== 1 || wa !== 1) $display("FAIL nv_write_pulse got n=%0d at=%0d want n=1 at=1", wn, wa); else passed++;
        total++; if (rn !== 0) $display("FAIL nv_read_pulse got %0d want 0", rn); else passed++;
        total++; if (q !== 16'h1234) $display("FAIL nv_data got %h want 1234", q); else passed++;
        total++; if (e !== 1'b0) $display("FAIL nv_err got %b want 0", e); else passed++;
        run_txn(1'b0, 1'b0, 16'h0000, lat, wn, rn, wa, ra, q, e);
        total++; if (q !== 16'h1234) $display("FAIL nv_readback got %h want 1234", q); else passed++;
    endtask

    task automatic test_backpressure();
        int acc_start; int k;
        @(negedge clk);
        acc_start = acc1;
        if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.req_data = 16'h0;
        @(posedge clk); #1;
        for (k = 0; k < 12 && !if1.rsp_valid; k++) begin @(posedge clk); #1; end
        total++; if (if1.rsp_valid !== 1'b1) $display("FAIL bp_rsp_arrives got %b want 1", if1.rsp_valid); else passed++;
        for (int c = 0; c < 5; c++) begin
            total++; if (if1.rsp_valid !== 1'b1) $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, if1.rsp_valid); else passed++;
            total++; if (if1.rsp_data !== 16'hA5A5) $display("FAIL bp_hold_data cycle %0d got %h want a5a5", c, if1.rsp_data); else passed++;
            total++; if (if1.req_ready !== 1'b0) $display("FAIL bp_hold_req_ready cycle %0d got %b want 0", c, if1.req_ready); else passed++;
            @(posedge clk); #1;
        end
        total++; if (acc1 - acc_start !== 1) $display("FAIL bp_accepts_during_hold got %0d want 1", acc1 - acc_start); else passed++;
        if1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if1.rsp_ready = 1'b0;
        total++; if (if1.req_ready !== 1'b1) $display("FAIL bp_back_to_idle got %b want 1", if1.req_ready); else passed++;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        total++; if (acc1 - acc_start !== 2) $display("FAIL bp_second_accept got %0d want 2", acc1 - acc_start); else passed++;
        for (k = 0; k < 12 && !if1.rsp_valid; k++) begin @(posedge clk); #1; end
        total++; if (if1.rsp_data !== 16'hA5A5 || if1.rsp_valid !== 1'b1) $display("FAIL bp_second_rsp got v=%b d=%h want v=1 d=a5a5", if1.rsp_valid, if1.rsp_data); else passed++;
        if1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if1.rsp_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        total++; if (acc1 - acc_start !== 2) $display("FAIL bp_no_extra_accept got %0d want 2", acc1 - acc_start); else passed++;
    endtask

    task automatic test_verify_fault();
        int lat, wn, rn, wa, ra; logic [15:0] q; logic e;
        fault_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b1, 1'b1, 16'h1234, lat, wn, rn, wa, ra, q, e);
            total++; if (e !== 1'b1 || q !== 16'h0000) $display("FAIL vf_rsp write %0d got err=%b d=%h want err=1 d=0000", i, e, q); else passed++;
            if (i == 0) begin
                total++; if (err_count1 !== 8'd1) $display("FAIL vf_count_first got %0d want 1", err_count1); else passed++;
            end
            if (i == 254) begin
                total++; if (err_count1 !== 8'd255) $display("FAIL vf_count_255 got %0d want 255", err_count1); else passed++;
            end
        end
        total++; if (err_count1 !== 8'd255) $display("FAIL vf_count_saturated got %0d want 255", err_count1); else passed++;
        fault_mode = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int lat, wn, rn, wa, ra; logic [15:0] q; logic e;
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = 1'b1; if1.req_data = 16'hBEEF;
        @(posedge clk); #1;
        if1.req_valid = 1'b0;
        total++; if (we1 !== 1'b1 || dbg1 !== 3'd1) $display("FAIL rm_in_wr got we=%b st=%0d want we=1 st=1", we1, dbg1); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (we1 !== 1'b0) $display("FAIL rm_we_drop got %b want 0", we1); else passed++;
        total++; if (if1.rsp_valid !== 1'b0) $display("FAIL rm_rsp_valid got %b want 0", if1.rsp_valid); else passed++;
        total++; if (if1.req_ready !== 1'b1) $display("FAIL rm_req_ready got %b want 1", if1.req_ready); else passed++;
        total++; if (err_count1 !== 8'd0) $display("FAIL rm_err_count got %0d want 0", err_count1); else passed++;
        total++; if (din1 !== 16'h0) $display("FAIL rm_data_in got %h want 0000", din1); else passed++;
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b1, 1'b0, 16'h0000, lat, wn, rn, wa, ra, q, e);
        total++; if (q !== 16'h0000 || lat !== 3) $display("FAIL rm_read_after got d=%h lat=%0d want d=0000 lat=3", q, lat); else passed++;
    endtask

    initial begin
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_data = 16'h0; if1.rsp_ready = 1'b0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_data = 16'h0; if0.rsp_ready = 1'b0;
        test_reset();
        test_read_after_reset();
        test_write_verify();
        test_no_verify();
        test_backpressure();
        test_verify_fault();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
